lap_record_uart_tx: RTL and testbench

Reads the lap-time record buffer of the digital clock and dumps every stored record, oldest first, as ASCII text over a UART line. It sits beside the record store: it drives the store's read address, takes the 32-bit packed-nibble record back, and serialises it on the board's USB-UART pin. It is the off-board read path for the stored laps; the display read path is unchanged.

---
 rtl/lap_record_uart_tx_pkg.sv | 52 +++++
 rtl/lap_record_uart_tx_byte.sv | 67 ++++++
 rtl/lap_record_uart_tx.sv | 142 ++++++++++++++
 tb/tb_lap_record_uart_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lap_record_uart_tx_pkg.sv
// rtl/lap_record_uart_tx_pkg.sv - shared types, ASCII constants and char helpers for the lap dump
//
// Purpose: FSM state type, record/ASCII constants and the nibble-to-ASCII
// mapping used by lap_record_uart_tx.
// Ports: none (package).

package lap_record_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    NEXT
  } state_e;

  localparam int         REC_DEPTH     = 16;
  localparam logic [3:0] LAST_ADDR     = 4'hF;
  localparam logic [3:0] CHARS_PER_REC = 4'd10;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Nibble value that the display uses as a separator; printed as ':'.
  localparam logic [3:0] NIB_COLON = 4'hA;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib <= 4'h9) begin
      return ASCII_ZERO + {4'h0, nib};
    end else if (nib == NIB_COLON) begin
      return ASCII_COLON;
    end else begin
      return ASCII_DASH;
    end
  endfunction

  // Character idx of a record line: 0..7 are nibbles from [31:28] down,
  // 8 is CR, 9 is LF.
  function automatic logic [7:0] record_char(input logic [31:0] rec,
                                             input logic [3:0]  idx);
    if (idx == 4'd8) begin
      return ASCII_CR;
    end else if (idx == 4'd9) begin
      return ASCII_LF;
    end else begin
      return nibble_to_ascii(rec[{3'd7 - idx[2:0], 2'b00} +: 4]);
    end
  endfunction

endpackage

// File: rtl/lap_record_uart_tx_byte.sv
// rtl/lap_record_uart_tx_byte.sv - 8N1 byte serialiser with baud counter
//
// Purpose: sends one byte per start request, LSB first, idle high.
// Ports:
//   sys_clk   clock
//   rst_n     asynchronous active-low reset
//   start     load data and begin a frame (taken when idle or in the last
//             stop-bit cycle, which gives back-to-back frames)
//   data      byte to send
//   txd       serial line
//   byte_done high during the last cycle of the stop bit

module uart_tx_byte #(
  parameter int BAUD_DIV = 868
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       byte_done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          active;
  logic          bit_end;

  assign bit_end   = active && (baud_cnt == CW'(BAUD_DIV - 1));
  assign byte_done = bit_end && (bit_cnt == 4'd9);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
      shreg    <= 9'h1FF;
      active   <= 1'b0;
      txd      <= 1'b1;
    end else if (start && (!active || byte_done)) begin
      // Start bit goes out immediately; the stop bit rides at the top of
      // the shifter so that it falls out after data[7].
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
      shreg    <= {1'b1, data};
      active   <= 1'b1;
      txd      <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          txd    <= 1'b1;
        end else begin
          txd     <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lap_record_uart_tx.sv
// rtl/lap_record_uart_tx.sv - dumps the lap-record store as ASCII lines over UART
//
// Purpose: on a dump request, reads records 16-N..15 (N = clamped rec_count)
// and sends each as 8 ASCII nibble characters plus CR LF.
// Ports:
//   sys_clk    clock
//   rst_n      asynchronous active-low reset
//   dump_flag  one-cycle dump request
//   rec_count  number of valid records (values above 16 act as 16)
//   rec_data   record at rd_addr, combinational from the store
//   rd_addr    record read address
//   uart_txd   serial line, 8N1, idle high
//   busy       dump in progress
//   done       one-cycle pulse at dump end (also for an empty store)

module lap_record_uart_tx
  import lap_record_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        dump_flag,
  input  logic [4:0]  rec_count,
  input  logic [31:0] rec_data,
  output logic [3:0]  rd_addr,
  output logic        uart_txd,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;

  state_e      state, state_nxt;
  logic [31:0] rec_reg, rec_nxt;
  logic [3:0]  char_idx, idx_nxt;
  logic [3:0]  rd_addr_nxt;
  logic        first_rec, first_nxt;
  logic        done_nxt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        byte_done;
  logic [4:0]  n_req;

  assign n_req = (rec_count > 5'(REC_DEPTH)) ? 5'(REC_DEPTH) : rec_count;
  assign busy  = (state != IDLE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rec_reg   <= 32'h0;
      char_idx  <= 4'd0;
      rd_addr   <= 4'd0;
      first_rec <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rec_reg   <= rec_nxt;
      char_idx  <= idx_nxt;
      rd_addr   <= rd_addr_nxt;
      first_rec <= first_nxt;
      done      <= done_nxt;
    end
  end

  // char_idx is the index of the next character to hand to the serialiser.
  always_comb begin
    state_nxt   = state;
    rec_nxt     = rec_reg;
    idx_nxt     = char_idx;
    rd_addr_nxt = rd_addr;
    first_nxt   = first_rec;
    done_nxt    = 1'b0;
    tx_start    = 1'b0;
    tx_data     = 8'h00;
    case (state)
      IDLE: begin
        if (dump_flag) begin
          if (n_req == 5'd0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt   = LOAD;
            rd_addr_nxt = 4'(5'(REC_DEPTH) - n_req);
            first_nxt   = 1'b1;
          end
        end
      end
      LOAD: begin
        rec_nxt   = rec_data;
        first_nxt = 1'b0;
        state_nxt = SEND;
        if (first_rec) begin
          idx_nxt = 4'd0;
        end else begin
          // Later records start their first char straight from the store
          // read so the inter-record gap is only NEXT + LOAD.
          tx_start = 1'b1;
          tx_data  = nibble_to_ascii(rec_data[31:28]);
          idx_nxt  = 4'd1;
        end
      end
      SEND: begin
        if (char_idx == 4'd0) begin
          tx_start = 1'b1;
          tx_data  = record_char(rec_reg, 4'd0);
          idx_nxt  = 4'd1;
        end else if (byte_done) begin
          if (char_idx == CHARS_PER_REC) begin
            state_nxt = NEXT;
          end else begin
            tx_start = 1'b1;
            tx_data  = record_char(rec_reg, char_idx);
            idx_nxt  = char_idx + 4'd1;
          end
        end
      end
      NEXT: begin
        if (rd_addr == LAST_ADDR) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          rd_addr_nxt = rd_addr + 4'd1;
          state_nxt   = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .start     (tx_start),
    .data      (tx_data),
    .txd       (uart_txd),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_lap_record_uart_tx.sv
// tb/tb_lap_record_uart_tx.sv - scoreboard bench for the lap record UART dump

module tb_lap_record_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int D        = 10;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dump_flag = 1'b0;
  logic [4:0]  rec_count = 5'd0;
  logic [31:0] rec_data;
  logic [3:0]  rd_addr;
  logic        uart_txd;
  logic        busy;
  logic        done;

  logic [31:0] mem [16];

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int extra_cnt = 0;
  int cyc       = 0;
  bit rx_en     = 1'b0;

  logic [7:0] exp_q [$];
  int         st_q  [$];

  lap_record_uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .dump_flag (dump_flag),
    .rec_count (rec_count),
    .rec_data  (rec_data),
    .rd_addr   (rd_addr),
    .uart_txd  (uart_txd),
    .busy      (busy),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always_comb rec_data = mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    if (n == 4'd10) return 8'h3A;
    return 8'h2D;
  endfunction

  task automatic push_record(input logic [31:0] r);
    for (int i = 0; i < 8; i++) exp_q.push_back(enc(r[31-4*i -: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART receiver: samples mid-bit and checks each byte against the queue.
  initial begin : rx_mon
    logic [7:0] rb;
    int t0;
    rb = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (rx_en && rst_n && uart_txd === 1'b0) begin
        t0 = cyc;
        repeat (D/2) @(negedge sys_clk);
        check("rx_start_bit", {31'b0, uart_txd}, 32'd0);
        for (int b = 0; b < 8; b++) begin
          repeat (D) @(negedge sys_clk);
          rb[b] = uart_txd;
        end
        repeat (D) @(negedge sys_clk);
        check("rx_stop_bit", {31'b0, uart_txd}, 32'd1);
        st_q.push_back(t0);
        if (exp_q.size() == 0) extra_cnt++;
        else check("rx_byte", {24'b0, rb}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic pulse_dump(output int ce);
    @(posedge sys_clk);
    #1 dump_flag = 1'b1;
    @(posedge sys_clk);
    #1 dump_flag = 1'b0;
    ce = cyc;
  endtask

  task automatic wait_dump(input int poke_at, output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    while (busy === 1'b1 && nbusy < 20000) begin
      nbusy++;
      if (done === 1'b1) ndone++;
      if (nbusy == poke_at) dump_flag = 1'b1;
      else if (nbusy == poke_at + 1) begin
        dump_flag = 1'b0;
        rec_count = 5'd5;
      end
      @(negedge sys_clk);
    end
    check("done_at_busy_fall", {31'b0, done}, 32'd1);
    if (done === 1'b1) ndone++;
    repeat (5) begin
      @(negedge sys_clk);
      if (done === 1'b1) ndone++;
    end
  endtask

  task automatic do_dump(input int n_rec, input int first_addr, input int poke_at, input string name);
    int ce, nb, nd, dl;
    st_q.delete();
    extra_cnt = 0;
    for (int a = 16 - n_rec; a < 16; a++) push_record(mem[a]);
    pulse_dump(ce);
    @(negedge sys_clk);
    check({name, "_busy_rise"}, {31'b0, busy}, 32'd1);
    check({name, "_first_addr"}, {28'b0, rd_addr}, first_addr);
    wait_dump(poke_at, nb, nd);
    check({name, "_busy_cycles"}, nb, n_rec * (100*D + 2) + 1);
    check({name, "_done_pulses"}, nd, 1);
    check({name, "_bytes_rx"}, st_q.size(), n_rec * 10);
    check({name, "_first_start"}, (st_q.size() > 0) ? st_q[0] - ce : -1, 2);
    for (int i = 1; i < st_q.size(); i++) begin
      dl = (i % 10 == 0) ? 10*D + 2 : 10*D;
      check({name, "_char_spacing"}, st_q[i] - st_q[i-1], dl);
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_extra"}, extra_cnt, 0);
    exp_q.delete();
  endtask

  initial begin : main
    int ce, lows, busys, dones;
    for (int k = 0; k < 16; k++) mem[k] = 32'h0;

    repeat (3) @(negedge sys_clk);
    check("reset_txd", {31'b0, uart_txd}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_addr", {28'b0, rd_addr}, 32'd0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (5) @(negedge sys_clk);

    mem[15] = 32'h12a34a56;
    rec_count = 5'd1;
    do_dump(1, 15, 0, "single");

    for (int k = 0; k < 16; k++) mem[k] = k;
    rec_count = 5'd16;
    do_dump(16, 0, 0, "full");

    rec_count = 5'd0;
    pulse_dump(ce);
    @(negedge sys_clk);
    check("empty_done", {31'b0, done}, 32'd1);
    check("empty_busy", {31'b0, busy}, 32'd0);
    lows = 0; busys = 0; dones = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
      if (done !== 1'b0) dones++;
    end
    check("empty_txd_low", lows, 0);
    check("empty_busy_after", busys, 0);
    check("empty_done_extra", dones, 0);

    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    rec_count = 5'd3;
    do_dump(3, 13, 300, "snapshot");

    rx_en = 1'b0;
    mem[15] = 32'h00000000;
    rec_count = 5'd1;
    pulse_dump(ce);
    repeat (55) @(negedge sys_clk);
    check("midreset_pre_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_txd", {31'b0, uart_txd}, 32'd1);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_addr", {28'b0, rd_addr}, 32'd0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    lows = 0; busys = 0;
    repeat (200) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check("postreset_txd_low", lows, 0);
    check("postreset_busy", busys, 0);
    rx_en = 1'b1;

    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    rec_count = 5'd20;
    do_dump(16, 0, 0, "clamp");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
